// File: rtl/perips_bus_arb.sv
// Round-robin arbiter for the shared peripheral/memory bus: three masters, one slave port,
// in-order responses routed back to the issuing master through an ID FIFO.
module perips_bus_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int OST_DEPTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [2:0]                    m_req_i,
  input  logic [2:0]                    m_we_i,
  input  logic [3*ADDR_WIDTH-1:0]       m_addr_i,
  input  logic [3*DATA_WIDTH-1:0]       m_wdata_i,
  input  logic [3*(DATA_WIDTH/8)-1:0]   m_wstrb_i,
  output logic [2:0]                    m_gnt_o,
  output logic [2:0]                    m_rvalid_o,
  output logic [DATA_WIDTH-1:0]         m_rdata_o,
  output logic                          slv_req_o,
  output logic                          slv_we_o,
  output logic [ADDR_WIDTH-1:0]         slv_addr_o,
  output logic [DATA_WIDTH-1:0]         slv_wdata_o,
  output logic [DATA_WIDTH/8-1:0]       slv_wstrb_o,
  input  logic                          slv_ready_i,
  input  logic                          slv_rvalid_i,
  input  logic [DATA_WIDTH-1:0]         slv_rdata_i,
  output logic [$clog2(OST_DEPTH):0]    ost_cnt_o,
  output logic                          err_o
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int PW = $clog2(OST_DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]    r_ptr;
  logic [1:0]    r_fifo [OST_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic          w_can_issue;
  logic          w_accept;
  logic          w_pop;
  logic          w_spurious;
  logic [1:0]    w_sel;
  logic [1:0]    w_head;
  logic [1:0]    w_next_ptr;

  function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= 3) s = s - 3;
    return 2'(s);
  endfunction

  // Scan ptr+2 down to ptr so the earliest requester in round-robin order wins.
  always_comb begin
    w_sel = r_ptr;
    for (int k = 2; k >= 0; k--) begin
      if (m_req_i[rr_idx(r_ptr, k)]) w_sel = rr_idx(r_ptr, k);
    end
  end

  // No push/pop bypass: a full FIFO blocks issue even if a response pops this cycle.
  assign w_can_issue = (r_cnt < CW'(OST_DEPTH));
  assign slv_req_o   = rst_n_i & w_can_issue & (|m_req_i);
  assign w_accept    = slv_req_o & slv_ready_i;
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_pop       = rst_n_i & slv_rvalid_i & (r_cnt != '0);
  assign w_spurious  = slv_rvalid_i & (r_cnt == '0);
  assign w_next_ptr  = (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;

  always_comb begin
    slv_we_o    = 1'b0;
    slv_addr_o  = '0;
    slv_wdata_o = '0;
    slv_wstrb_o = '0;
    m_gnt_o     = '0;
    if (slv_req_o) begin
      slv_we_o       = m_we_i[w_sel];
      slv_addr_o     = m_addr_i[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
      slv_wdata_o    = m_wdata_i[w_sel*DATA_WIDTH +: DATA_WIDTH];
      slv_wstrb_o    = m_wstrb_i[w_sel*SW +: SW];
      m_gnt_o[w_sel] = slv_ready_i;
    end
  end

  assign m_rvalid_o = w_pop ? (3'b001 << w_head) : 3'b000;
  assign m_rdata_o  = w_pop ? slv_rdata_i : '0;
  assign ost_cnt_o  = r_cnt;
  assign err_o      = r_err;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ptr    <= 2'd0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_ptr    <= w_next_ptr;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_spurious) r_err <= 1'b1;
    end
  end

  // ID storage needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (w_accept) r_fifo[r_wr_ptr] <= w_sel;
  end

endmodule

// File: tb/tb_perips_bus_arb.sv
// Bench for perips_bus_arb: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a queue-based round-robin model.
module tb_perips_bus_arb;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int OST = 4;
  localparam int CW  = $clog2(OST) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [2:0]        m_req, m_we;
  logic [3*AW-1:0]   m_addr;
  logic [3*DW-1:0]   m_wdata;
  logic [3*SW-1:0]   m_wstrb;
  logic [2:0]        m_gnt, m_rvalid;
  logic [DW-1:0]     m_rdata;
  logic              slv_req, slv_we;
  logic [AW-1:0]     slv_addr;
  logic [DW-1:0]     slv_wdata;
  logic [SW-1:0]     slv_wstrb;
  logic              slv_ready, slv_rvalid;
  logic [DW-1:0]     slv_rdata;
  logic [CW-1:0]     ost_cnt;
  logic              err;

  perips_bus_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OST_DEPTH(OST)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_req_i(m_req), .m_we_i(m_we), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .slv_req_o(slv_req), .slv_we_o(slv_we), .slv_addr_o(slv_addr),
    .slv_wdata_o(slv_wdata), .slv_wstrb_o(slv_wstrb),
    .slv_ready_i(slv_ready), .slv_rvalid_i(slv_rvalid), .slv_rdata_i(slv_rdata),
    .ost_cnt_o(ost_cnt), .err_o(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] tag(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: outstanding master IDs and expected response data in issue order.
  int            md_ptr = 0;
  int            md_id[$];
  logic [DW-1:0] md_dat[$];
  bit            md_err = 1'b0;
  logic [2:0]    e_gnt_last = '0;
  bit            acc_last = 1'b0;
  logic [AW-1:0] acc_addr_last = '0;
  bit            auto_en = 1'b0;
  logic [DW-1:0] sq[$];

  always @(negedge clk) begin : cmp
    logic [2:0]    e_gnt, e_rv;
    logic          e_req, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd;
    logic [SW-1:0] e_ws;
    int            s;
    e_gnt = '0; e_rv = '0; e_req = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wd = '0; e_rd = '0; e_ws = '0; s = 0;
    if (rst_n) begin
      if (md_id.size() < OST && m_req != 3'b000) begin
        e_req = 1'b1;
        for (int k = 2; k >= 0; k--) if (m_req[(md_ptr + k) % 3]) s = (md_ptr + k) % 3;
        e_we   = m_we[s];
        e_addr = m_addr[s*AW +: AW];
        e_wd   = m_wdata[s*DW +: DW];
        e_ws   = m_wstrb[s*SW +: SW];
        if (slv_ready) e_gnt[s] = 1'b1;
      end
      if (slv_rvalid && md_id.size() > 0) begin
        e_rv[md_id[0]] = 1'b1;
        e_rd = slv_rdata;
      end
    end
    chk("gnt", m_gnt, e_gnt);
    chk("slv_req", slv_req, e_req);
    chk("slv_we", slv_we, e_we);
    chk("slv_addr", slv_addr, e_addr);
    chk("slv_wdata", slv_wdata, e_wd);
    chk("slv_wstrb", slv_wstrb, e_ws);
    chk("rvalid", m_rvalid, e_rv);
    chk("rdata", m_rdata, e_rd);
    chk("ost_cnt", ost_cnt, md_id.size());
    chk("err", err, md_err);
    if (auto_en && e_rv != 3'b000) chk("rsp_tag", m_rdata, md_dat[0]);
    e_gnt_last    = e_gnt;
    acc_last      = slv_req & slv_ready & rst_n;
    acc_addr_last = slv_addr;
    if (!rst_n) begin
      md_ptr = 0; md_id.delete(); md_dat.delete(); md_err = 1'b0;
    end else begin
      if (slv_rvalid) begin
        if (md_id.size() > 0) begin
          void'(md_id.pop_front());
          void'(md_dat.pop_front());
        end else md_err = 1'b1;
      end
      if (e_gnt != 3'b000) begin
        md_id.push_back(s);
        md_dat.push_back(tag(e_addr));
        md_ptr = (s + 1) % 3;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic probe();
    @(negedge clk); #1;
  endtask

  task automatic drv(input logic [2:0] req, input logic rdy, input logic rv);
    step();
    m_req = req; slv_ready = rdy; slv_rvalid = rv; slv_rdata = $urandom();
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0; m_req = '0; m_we = 3'b010; slv_ready = 1'b0; slv_rvalid = 1'b0; slv_rdata = '0;
    m_addr  = {32'h2000_0300, 32'h1000_0200, 32'h0000_0100};
    m_wdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    m_wstrb = {4'hC, 4'h3, 4'hF};
    auto_en = 1'b0;
    sq.delete();
    step(); step();
    rst_n = 1'b1;
  endtask

  // Masters hold until granted; the slave answers in order from its own queue.
  task automatic auto_drive(input int req_pct, input int rdy_pct, input int rv_pct);
    if (slv_rvalid && sq.size() > 0) void'(sq.pop_front());
    if (acc_last) sq.push_back(tag(acc_addr_last));
    slv_rvalid = (sq.size() > 0) && ($urandom_range(99) < rv_pct);
    slv_rdata  = slv_rvalid ? sq[0] : $urandom();
    slv_ready  = ($urandom_range(99) < rdy_pct);
    for (int k = 0; k < 3; k++) begin
      if (!m_req[k] || e_gnt_last[k]) begin
        m_req[k]            = ($urandom_range(99) < req_pct);
        m_we[k]             = 1'($urandom_range(1));
        m_addr[k*AW +: AW]  = {k[1:0], 30'($urandom())};
        m_wdata[k*DW +: DW] = $urandom();
        m_wstrb[k*SW +: SW] = SW'($urandom());
      end
    end
  endtask

  int rq_t[4] = '{90, 50, 100, 30};
  int rd_t[4] = '{100, 60, 80, 40};
  int rv_t[4] = '{100, 50, 20, 70};

  initial begin
    rst_n = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    slv_ready = 1'b0; slv_rvalid = 1'b0; slv_rdata = '0;

    do_reset();
    probe();
    chk("rst_cnt", ost_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_gnt", m_gnt, 3'b000);
    chk("rst_slv_req", slv_req, 0);

    // All masters request continuously with a one-cycle slave.
    auto_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      auto_drive(100, 100, 100);
      probe();
      chk("rot_gnt", m_gnt, 3'b001 << (i % 3));
      if (i > 0) chk("rot_rvalid", m_rvalid, 3'b001 << ((i - 1) % 3));
    end

    // m1 alone, then m0 and m2 together.
    do_reset();
    repeat (3) begin drv(3'b010, 1'b1, 1'b0); probe(); chk("m1_gnt", m_gnt, 3'b010); end
    drv(3'b101, 1'b1, 1'b1); probe();
    chk("m2_first", m_gnt, 3'b100); chk("m1_rsp_a", m_rvalid, 3'b010); chk("m1_cnt", ost_cnt, 3);
    drv(3'b001, 1'b1, 1'b1); probe();
    chk("m0_second", m_gnt, 3'b001); chk("m1_rsp_b", m_rvalid, 3'b010);
    drv(3'b000, 1'b0, 1'b1); probe(); chk("drain_m1", m_rvalid, 3'b010);
    drv(3'b000, 1'b0, 1'b1); probe(); chk("drain_m2", m_rvalid, 3'b100);
    drv(3'b000, 1'b0, 1'b1); probe(); chk("drain_m0", m_rvalid, 3'b001);

    // Fill to OST_DEPTH, then a response alongside a request.
    do_reset();
    repeat (4) begin drv(3'b001, 1'b1, 1'b0); probe(); chk("fill_gnt", m_gnt, 3'b001); end
    drv(3'b001, 1'b1, 1'b0); probe();
    chk("full_slv_req", slv_req, 0); chk("full_gnt", m_gnt, 3'b000); chk("full_cnt", ost_cnt, 4);
    drv(3'b001, 1'b1, 1'b1); probe();
    chk("full_pop_gnt", m_gnt, 3'b000); chk("full_pop_rv", m_rvalid, 3'b001);
    drv(3'b001, 1'b1, 1'b0); probe();
    chk("refill_gnt", m_gnt, 3'b001); chk("refill_cnt", ost_cnt, 3);
    repeat (4) begin drv(3'b000, 1'b0, 1'b1); probe(); chk("full_drain", m_rvalid, 3'b001); end

    // Spurious response with nothing outstanding.
    drv(3'b000, 1'b0, 1'b1); probe();
    chk("spur_rv", m_rvalid, 3'b000); chk("spur_err_pre", err, 0);
    drv(3'b000, 1'b0, 1'b0); probe(); chk("spur_err", err, 1);
    repeat (3) drv(3'b000, 1'b0, 1'b0);
    probe(); chk("spur_sticky", err, 1);

    // Slave stalls with m0 requesting.
    do_reset();
    repeat (3) begin
      drv(3'b001, 1'b0, 1'b0); probe();
      chk("stall_gnt", m_gnt, 3'b000); chk("stall_req", slv_req, 1);
      chk("stall_addr", slv_addr, 32'h0000_0100);
    end
    drv(3'b001, 1'b1, 1'b0); probe(); chk("stall_release", m_gnt, 3'b001);
    drv(3'b011, 1'b1, 1'b0); probe(); chk("ptr_advance", m_gnt, 3'b010);

    // Reset with three outstanding, then a late response.
    do_reset();
    repeat (3) drv(3'b111, 1'b1, 1'b0);
    step(); rst_n = 1'b0; probe();
    chk("inrst_gnt", m_gnt, 3'b000); chk("inrst_slv_req", slv_req, 0);
    step(); rst_n = 1'b1; m_req = 3'b000; slv_ready = 1'b0; probe();
    chk("postrst_cnt", ost_cnt, 0);
    drv(3'b000, 1'b0, 1'b1); probe(); chk("late_rv", m_rvalid, 3'b000);
    drv(3'b111, 1'b1, 1'b0); probe();
    chk("late_err", err, 1); chk("postrst_ptr", m_gnt, 3'b001);

    // Randomized traffic.
    for (int p = 0; p < 4; p++) begin
      do_reset();
      auto_en = 1'b1;
      for (int c = 0; c < 600; c++) begin
        step();
        auto_drive(rq_t[p], rd_t[p], rv_t[p]);
      end
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perips_bus_arb.md
# perips_bus_arb

Round-robin arbiter sharing the single-port peripheral/memory bus (ROM/RAM/UART slave side) among three masters: core instruction fetch (m0), core load/store unit (m1) and debug/loader port (m2). It sits between `core_top` and the peripheral decoder in `chip_top`. It grants one request per cycle and tracks up to `OST_DEPTH` outstanding transactions in an ID FIFO. In-order slave responses are routed back to the issuing master.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width per master
- `DATA_WIDTH`, 32, data width; strobe width is `DATA_WIDTH/8`
- `OST_DEPTH`, 4, maximum outstanding accepted transactions (power of two, 2..8)

Ports (`m_*` buses are packed, master k in slice k):
- `clk_i`  in  1  system clock
- `rst_n_i`  in  1  reset; one clock; reset is synchronous and active-low
- `m_req_i`  in  3  request per master
- `m_we_i`  in  3  write enable per master
- `m_addr_i`  in  3*ADDR_WIDTH  addresses
- `m_wdata_i`  in  3*DATA_WIDTH  write data
- `m_wstrb_i`  in  3*DATA_WIDTH/8  byte strobes
- `m_gnt_o`  out  3  one-hot accept pulse; request consumed this cycle
- `m_rvalid_o`  out  3  one-hot response valid
- `m_rdata_o`  out  DATA_WIDTH  response data, shared by all masters, qualified by `m_rvalid_o`
- `slv_req_o`, `slv_we_o`  out  1  slave request / write
- `slv_addr_o`, `slv_wdata_o`, `slv_wstrb_o`  out  matching widths  muxed from the winning master
- `slv_ready_i`  in  1  slave can accept this cycle
- `slv_rvalid_i`  in  1  in-order response, one per accepted request (writes included, as ack)
- `slv_rdata_i`  in  DATA_WIDTH  response data
- `ost_cnt_o`  out  $clog2(OST_DEPTH)+1  current outstanding count
- `err_o`  out  1  sticky: response received with no outstanding transaction

## Operation
- Registered state:
  - RR pointer `ptr` (0..2)
  - ID FIFO of 2-bit master IDs, depth `OST_DEPTH`, with wr/rd pointers and count
  - `err` flag
- Eligibility: `can_issue = (count < OST_DEPTH)`. No push/pop bypass: when full, nothing is issued even if a pop occurs in the same cycle.
- Selection (combinational): first requesting master scanning ptr, ptr+1, ptr+2 (mod 3).
- `slv_req_o = can_issue & |m_req_i`. The slave fields mux from the selected master. When `slv_req_o`=0 the fields are driven 0.
- Accept = `slv_req_o & slv_ready_i`. On accept:
  - `m_gnt_o[sel]` = 1
  - push `sel` into the FIFO
  - `ptr <= (sel+1) mod 3`
- `ptr` is unchanged when nothing is accepted. A master must hold its req and fields stable until granted.
- Response: if `slv_rvalid_i` and count>0:
  - `m_rvalid_o[fifo_head]` = 1 and `m_rdata_o = slv_rdata_i` (combinational pass-through)
  - pop
- If `slv_rvalid_i` and count==0: no rvalid, `err` set, held until reset.
- Simultaneous accept and response: push and pop in the same cycle, count unchanged. The response routes to the old head.
- The FIFO pointers wrap mod `OST_DEPTH`.

## Timing
- Reset (sync, `rst_n_i`=0 at posedge) clears:
  - ptr=0
  - FIFO empty, `ost_cnt_o`=0
  - `err_o`=0
- Reset mid-operation discards all outstanding IDs. Responses arriving afterwards raise `err_o`.
- Outputs while in reset or idle: `m_gnt_o`=0, `m_rvalid_o`=0, `slv_req_o`=0, data outputs 0.
- Grant latency: 0 cycles. `m_gnt_o` is combinational in the cycle `slv_ready_i` is high.
- Response latency: set entirely by the slave. The arbiter adds 0 cycles.
- `ost_cnt_o` and `err_o` are registered and update at the edge after the event.
- Maximum throughput: 1 accept per cycle while count < `OST_DEPTH`.

## Test plan
- All three masters request continuously, slave ready, 1-cycle response → grants rotate m0,m1,m2,m0,…. Each master receives rvalid in the cycle after its grant with data matching the address tag.
- m1 alone requests for 3 cycles with ptr=0 → m1 granted every cycle and ptr settles at 2. Then m0 and m2 request together → m2 granted first, then m0.
- Slave holds rvalid low and accepts 4 requests → `ost_cnt_o`=4, and `slv_req_o`=0 on the 5th request. A response and a new request arriving in the same cycle → no grant that cycle, grant the next cycle.
- `slv_ready_i`=0 for 3 cycles with m0 requesting → no grant, ptr stays 0, `slv_addr_o` = m0 address throughout. Ready rises → single grant to m0.
- Spurious `slv_rvalid_i` with count=0 → no `m_rvalid_o`, `err_o`=1 the next cycle and it stays 1.
- Reset asserted with 3 outstanding → `ost_cnt_o`=0, ptr=0. A late response after reset sets `err_o`.
